lfo_scheduler: RTL

Time-multiplexed multi-channel triangle LFO engine. One shared update unit is rotated round-robin across NUM_CH channel state slots, so each channel advances only in its own slot. Each channel has its own run-time rate, step and depth, written through a single config port by the control/UI logic. Outputs feed the effect modulation inputs (tremolo, filter sweep, pitch wobble) as 10-bit unsigned values.

---
 rtl/lfo_pkg.sv | 41 ++++
 rtl/lfo_step_unit.sv | 41 ++++
 rtl/lfo_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/lfo_pkg.sv
// Shared types, widths and helpers for the time-multiplexed triangle LFO engine.
package lfo_pkg;

  localparam int unsigned NUM_CH_DEF   = 4;
  localparam int unsigned PERIOD_W_DEF = 17;
  localparam int unsigned TRI_W        = 10;
  localparam int unsigned STEP_W       = 4;
  localparam int unsigned DEPTH_W      = 9;
  localparam int unsigned PROD_W       = TRI_W + DEPTH_W;
  localparam int unsigned TRI_MAX      = 1023;
  localparam int unsigned DEPTH_UNITY  = 256;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } lfo_dir_e;

  typedef struct packed {
    logic                    en;
    logic [PERIOD_W_DEF-1:0] period;
    logic [STEP_W-1:0]       step;
    logic [DEPTH_W-1:0]      depth;
  } lfo_cfg_t;

  typedef struct packed {
    logic [TRI_W-1:0]        tri_val;
    lfo_dir_e                dir;
    logic [PERIOD_W_DEF-1:0] div;
  } lfo_state_t;

  // Gain stage: depth saturates at unity (256), result is (tri*depth)>>8 truncated.
  function automatic logic [TRI_W-1:0] depth_scale(input logic [TRI_W-1:0]   tri_val,
                                                   input logic [DEPTH_W-1:0] depth);
    logic [DEPTH_W-1:0] gain;
    logic [PROD_W-1:0]  prod;
    gain = (depth > DEPTH_W'(DEPTH_UNITY)) ? DEPTH_W'(DEPTH_UNITY) : depth;
    prod = (PROD_W'(tri_val) * PROD_W'(gain)) >> 8;
    return TRI_W'(prod);
  endfunction

endpackage

// File: rtl/lfo_step_unit.sv
// Single shared triangle stepper; reflects off 0 and TRI_MAX, step 0 acts as 1.
module lfo_step_unit
  import lfo_pkg::*;
(
  input  logic [TRI_W-1:0]  cur_tri,
  input  lfo_dir_e          cur_dir,
  input  logic [STEP_W-1:0] step,
  output logic [TRI_W-1:0]  next_tri,
  output lfo_dir_e          next_dir
);

  localparam int unsigned CALC_W = 11;

  logic [CALC_W-1:0] s;
  logic [CALC_W-1:0] t;
  logic [CALC_W-1:0] sum;

  always_comb begin
    s        = (step == '0) ? CALC_W'(1) : CALC_W'(step);
    t        = CALC_W'(cur_tri);
    sum      = t + s;
    next_tri = cur_tri;
    next_dir = cur_dir;
    if (cur_dir == DIR_UP) begin
      if (sum > CALC_W'(TRI_MAX)) begin
        next_tri = TRI_W'(CALC_W'(2 * TRI_MAX) - sum);
        next_dir = DIR_DOWN;
      end else begin
        next_tri = TRI_W'(sum);
      end
    end else begin
      if (t < s) begin
        next_tri = TRI_W'(s - t);
        next_dir = DIR_UP;
      end else begin
        next_tri = TRI_W'(t - s);
      end
    end
  end

endmodule

// File: rtl/lfo_scheduler.sv
// Round-robin multi-channel triangle LFO: one step unit visits one channel slot per cycle,
// with per-channel config written through a single port and a registered depth-scaled output.
module lfo_scheduler
  import lfo_pkg::*;
#(
  parameter int unsigned        NUM_CH     = NUM_CH_DEF,
  parameter int unsigned        PERIOD_W   = PERIOD_W_DEF,
  parameter logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(4095)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_valid,
  input  logic [$clog2(NUM_CH)-1:0]   cfg_ch,
  input  logic                        cfg_en,
  input  logic [PERIOD_W-1:0]         cfg_period,
  input  logic [STEP_W-1:0]           cfg_step,
  input  logic [DEPTH_W-1:0]          cfg_depth,
  input  logic                        cfg_phase_rst,
  output logic [NUM_CH*TRI_W-1:0]     out_flat,
  output logic                        out_valid,
  output logic [$clog2(NUM_CH)-1:0]   out_ch
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  lfo_cfg_t         cfg_q [NUM_CH];
  lfo_state_t       st_q  [NUM_CH];
  logic [TRI_W-1:0] out_q [NUM_CH];
  logic [CH_W-1:0]  slot;

  lfo_cfg_t         wr_cfg;
  lfo_cfg_t         cur_cfg;
  lfo_state_t       cur_st;
  lfo_state_t       svc_st;
  logic [DEPTH_W-1:0] svc_depth;
  logic             collide;
  logic [TRI_W-1:0] step_tri;
  lfo_dir_e         step_dir;

  lfo_step_unit u_step (
    .cur_tri  (cur_st.tri_val),
    .cur_dir  (cur_st.dir),
    .step     (cur_cfg.step),
    .next_tri (step_tri),
    .next_dir (step_dir)
  );

  // Service of the current slot; a same-channel write overrides the update.
  always_comb begin
    wr_cfg    = '{en: cfg_en, period: PERIOD_W_DEF'(cfg_period), step: cfg_step, depth: cfg_depth};
    cur_cfg   = cfg_q[slot];
    cur_st    = st_q[slot];
    collide   = cfg_valid && (cfg_ch == slot);
    svc_st    = cur_st;
    svc_depth = cur_cfg.depth;
    if (collide) begin
      svc_depth = wr_cfg.depth;
      if (cfg_phase_rst) begin
        svc_st = '{tri_val: '0, dir: DIR_UP, div: wr_cfg.period};
      end
    end else if (cur_cfg.en) begin
      if (cur_st.div != '0) begin
        svc_st.div = cur_st.div - PERIOD_W_DEF'(1);
      end else begin
        svc_st.div     = cur_cfg.period;
        svc_st.tri_val = step_tri;
        svc_st.dir     = step_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_q[c] <= '{en: 1'b0, period: PERIOD_W_DEF'(RST_PERIOD),
                      step: STEP_W'(1), depth: DEPTH_W'(DEPTH_UNITY)};
        st_q[c]  <= '{tri_val: '0, dir: DIR_UP, div: '0};
        out_q[c] <= '0;
      end
    end else begin
      slot <= slot + CH_W'(1);
      if (cfg_valid) begin
        cfg_q[cfg_ch] <= wr_cfg;
        if (cfg_phase_rst) begin
          st_q[cfg_ch] <= '{tri_val: '0, dir: DIR_UP, div: wr_cfg.period};
        end
      end
      if (!collide) begin
        st_q[slot] <= svc_st;
      end
      out_q[slot] <= depth_scale(svc_st.tri_val, svc_depth);
      out_valid   <= 1'b1;
      out_ch      <= slot;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign out_flat[c*TRI_W +: TRI_W] = out_q[c];
  end

endmodule
